// File: rtl/des_sbox_compress.sv
// des_sbox_compress
//   Iterative DES Feistel back-end. Takes the 48-bit key-mixed word and
//   applies one S-box per cycle, S1 first. After S8 it applies the P
//   permutation and presents the 32-bit f-function result.
//
// Ports
//   wClk         clock, rising edge
//   wResetN      synchronous active-low reset
//   wInputData   48-bit key-mixed word (DES bit 1 = Verilog index 48)
//   wInValid     input word valid
//   rInReady     block idle and able to accept a word
//   rOutputData  P-permuted S-box result (DES bit 1 = Verilog index 32)
//   rOutValid    rOutputData valid
//   wOutReady    downstream accepts rOutputData
//
// Bit numbering: with the [N:1] declarations, Verilog index N is the MSB.
// DES bit k therefore lives at index N+1-k. The P permutation below
// converts between the two numberings.

module des_sbox_compress (
    input  logic        wClk,
    input  logic        wResetN,
    input  logic [48:1] wInputData,
    input  logic        wInValid,
    output logic        rInReady,
    output logic [32:1] rOutputData,
    output logic        rOutValid,
    input  logic        wOutReady
);

    typedef enum logic [1:0] {IDLE, SUB, OUT} state_t;

    // One 64-entry table per S-box. Entry (row*16 + col) is the nibble at
    // hex digit position row*16+col, counting from the left.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // P table in DES numbering: output bit i+1 takes pre-P bit P_TAB[i].
    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [32:1] p_perm(input logic [32:1] x);
        logic [32:1] y;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            y[32 - i] = x[33 - P_TAB[i]];
        end
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [48:1] shift_q, shift_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [32:1] acc_q,   acc_d;
    logic [32:1] out_q,   out_d;

    // Single shared S-box lookup on the top six bits of the shift register.
    logic [5:0]   grp;
    logic [5:0]   idx;
    logic [255:0] tbl_shift;
    logic [3:0]   nib;
    logic [32:1]  pre_p;

    always_comb begin
        grp       = shift_q[48:43];
        idx       = {grp[5], grp[0], grp[4:1]};     // {row, column}
        tbl_shift = SBOX[cnt_q] << {idx, 2'b00};
        nib       = tbl_shift[255:252];
        pre_p     = {acc_q[28:1], nib};              // includes this cycle's nibble
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (wInValid) begin
                    shift_d = wInputData;
                    cnt_d   = 3'd0;
                    state_d = SUB;
                end
            end
            SUB: begin
                acc_d   = pre_p;
                shift_d = {shift_q[42:1], 6'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    out_d   = p_perm(pre_p);
                    state_d = OUT;
                end
            end
            OUT: begin
                if (wOutReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wClk) begin
        if (!wResetN) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign rInReady    = (state_q == IDLE);
    assign rOutValid   = (state_q == OUT);
    assign rOutputData = out_q;

endmodule

// File: doc/des_sbox_compress.md
# des_sbox_compress

Iterative DES Feistel back-end: takes the 48-bit key-mixed word that follows the expansion box and the round-key XOR. It runs it through the eight DES S-boxes, one S-box per cycle, then applies the P permutation to produce the 32-bit Feistel output. It sits between the round-key XOR and the L/R swap in the round datapath and is the 48-to-32 counterpart of the 32-to-48 expansion stage. Flow control uses valid/ready on both sides.

## Interface
- No parameters; widths fixed by FIPS 46-3.
- wClk  input  1  clock; all state changes on rising edge.
- wResetN  input  1  synchronous, active-low reset, sampled on rising edge of wClk.
- wInputData  input  [48:1]  key-mixed word, DES numbering (bit 1 = MSB); bits 1–6 feed S1, …, bits 43–48 feed S8.
- wInValid  input  1  wInputData valid.
- rInReady  output  1  block can accept a word.
- rOutputData  output  [32:1]  P-permuted S-box result, DES numbering.
- rOutValid  output  1  rOutputData valid.
- wOutReady  input  1  downstream accepts rOutputData.

## Operation
- Reset (wResetN low at an edge): state IDLE, rInReady=1, rOutValid=0, rOutputData=0, internal shift register and counter cleared. Reset overrides every other event, including a handshake in the same cycle.
- States: IDLE, SUB, OUT.
- IDLE: rInReady=1. On wInValid=1, capture wInputData into the 48-bit shift register, clear the 3-bit counter, go to SUB.
- SUB: rInReady=0. Each cycle, take the top 6 bits b1..b6:
  - row = {b1,b6}, column = {b2,b3,b4,b5}.
  - Look up S[counter+1] using the standard FIPS 46-3 tables.
  - Shift the 4-bit result into the 32-bit accumulator from the LSB side.
  - Shift the input register left by 6.
  - Increment the counter.
  - After the counter=7 cycle, load rOutputData with P(accumulator including this cycle's nibble), set rOutValid=1, go to OUT.
- P table (output bit i ← pre-P bit): 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
- OUT: rOutValid=1, rInReady=0, rOutputData held stable.
  - On wOutReady=1: clear rOutValid, go to IDLE.
  - With wOutReady=0: hold indefinitely (backpressure).
- wInValid while not in IDLE is ignored; the upstream must hold the word, since it is not accepted.
- No overlap: the input handshake is never accepted in the same cycle as the output handshake.
- The S-box lookup is one shared combinational 8×64×4 table selected by the counter. There is exactly one lookup per cycle.

## Timing
- Input accept edge = cycle 0.
- SUB occupies cycles 1–8: S1 at cycle 1, S8 at cycle 8.
- rOutValid rises after the cycle-8 edge. The output is visible during cycle 9 (latency 9 cycles from accept to valid).
- With wOutReady held high: output handshake at the cycle-9 edge, rInReady=1 during cycle 10, so the next accept happens at the cycle-10 edge. Maximum throughput is 1 word per 10 cycles.
- Counter wraps 7→0 only on the transition to OUT; the counter is don't-care outside SUB.
- Reset asserted mid-SUB or in OUT discards the word. No output is produced, and rInReady=1 on the first cycle after reset deasserts.
- rOutputData changes only on the SUB→OUT transition or on reset.

## Test plan
- Reset: hold wResetN=0 for 3 cycles with wInValid=1 → rInReady=1, rOutValid=0, rOutputData=0x00000000; no capture occurs.
- All-zero input: wInputData=0x000000000000 → pre-P 0xEFA72C4D; rOutputData=0xD8D8DBBC with rOutValid high 9 cycles after accept.
- All-ones input: wInputData=0xFFFFFFFFFFFF → pre-P 0xD9CE3DCB; rOutputData=0x38DBF9CB.
- Backpressure: all-zero input, wOutReady=0 for 20 cycles after valid → rOutValid and rOutputData=0xD8D8DBBC stable throughout, rInReady=0, a second wInValid is ignored. Raise wOutReady → rOutValid falls the next cycle, and rInReady=1.
- Back-to-back: two words presented continuously with wOutReady=1 → accepts 10 cycles apart, outputs in order, each matching the software DES f-function model (random 1000-word sweep vs. golden model).
- Reset mid-operation: assert wResetN=0 at cycle 4 of SUB → no rOutValid pulse. A subsequent word processes normally with correct result.
